// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one radix-4 Booth pipelined multiplier among NUM_REQ requesters.
// Define MULT_SHARE_ARB_STATS_EN to add the issue_cnt / starve_cnt statistics outputs.

module optmult #(
  parameter int M_W      = 8,
  parameter int N_W      = 8,
  parameter int UNSIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [M_W-1:0]     a,
  input  logic [N_W-1:0]     b,
  output logic [M_W+N_W-1:0] out
);

  localparam int NX  = (UNSIGNED != 0) ? ((N_W % 2 != 0) ? N_W + 1 : N_W + 2)
                                       : ((N_W % 2 != 0) ? N_W + 1 : N_W);
  localparam int LAT = (NX / 2 + 1) / 2;
  localparam int PW  = M_W + N_W;
  // b is widened so every stage can consume two Booth digits; the surplus top digits
  // only see extension bits and therefore contribute zero.
  localparam int BXW = 4 * LAT + 1;

  logic signed [PW-1:0] a_ext;
  logic        [BXW-1:0] b_ext;
  logic signed [PW-1:0] a_q   [LAT];
  logic        [BXW-1:0] bx_q [LAT];
  logic signed [PW-1:0] sum_q [LAT];

  function automatic logic signed [PW-1:0] booth_pp(input logic signed [PW-1:0] ma,
                                                    input logic [BXW-1:0]      mb,
                                                    input int                  j);
    logic signed [PW-1:0] m;
    case (mb[2*j +: 3])
      3'b001, 3'b010: m = ma;
      3'b011:         m = ma <<< 1;
      3'b100:         m = -(ma <<< 1);
      3'b101, 3'b110: m = -ma;
      default:        m = '0;
    endcase
    return m <<< (2 * j);
  endfunction

  always_comb begin
    a_ext = PW'(a);
    b_ext = '0;
    b_ext[N_W:1] = b;
    if (UNSIGNED == 0) begin
      for (int i = M_W; i < PW; i++) a_ext[i] = a[M_W-1];
      for (int i = N_W + 1; i < BXW; i++) b_ext[i] = b[N_W-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        a_q[s]   <= '0;
        bx_q[s]  <= '0;
        sum_q[s] <= '0;
      end
    end else begin
      a_q[0]   <= a_ext;
      bx_q[0]  <= b_ext;
      sum_q[0] <= booth_pp(a_ext, b_ext, 0) + booth_pp(a_ext, b_ext, 1);
      for (int s = 1; s < LAT; s++) begin
        a_q[s]   <= a_q[s-1];
        bx_q[s]  <= bx_q[s-1];
        sum_q[s] <= sum_q[s-1] + booth_pp(a_q[s-1], bx_q[s-1], 2 * s)
                               + booth_pp(a_q[s-1], bx_q[s-1], 2 * s + 1);
      end
    end
  end

  assign out = sum_q[LAT-1];

endmodule

module mult_share_arb #(
  parameter int  NUM_REQ  = 4,
  parameter int  M_W      = 8,
  parameter int  N_W      = 8,
  parameter int  UNSIGNED = 0,
  localparam int ID_W     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*M_W-1:0] req_a,
  input  logic [NUM_REQ*N_W-1:0] req_b,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic [M_W+N_W-1:0]     res_out,
  output logic                   busy
`ifdef MULT_SHARE_ARB_STATS_EN
  ,
  output logic [31:0]            issue_cnt,
  output logic [31:0]            starve_cnt
`endif
);

  localparam int NX  = (UNSIGNED != 0) ? ((N_W % 2 != 0) ? N_W + 1 : N_W + 2)
                                       : ((N_W % 2 != 0) ? N_W + 1 : N_W);
  localparam int LAT = (NX / 2 + 1) / 2;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               xfer;
  logic               iss_vld_q;
  logic [ID_W-1:0]    iss_id_q;
  logic [M_W-1:0]     iss_a_q;
  logic [N_W-1:0]     iss_b_q;
  logic               tag_vld_q [LAT];
  logic [ID_W-1:0]    tag_id_q  [LAT];
  logic [M_W+N_W-1:0] mult_out;

  // Rotating priority search; reset also forces the grant low so nothing is accepted.
  always_comb begin
    int  idx;
    logic found;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && en && rst && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = ID_W'(idx);
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q  <= '0;
      iss_vld_q <= 1'b0;
      iss_id_q  <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_id_q[s]  <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      iss_vld_q <= xfer;
      if (xfer) iss_id_q <= gnt_idx;
      tag_vld_q[0] <= iss_vld_q;
      tag_id_q[0]  <= iss_id_q;
      for (int s = 1; s < LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  // Operand registers carry no reset; their contents only matter alongside iss_vld_q.
  always_ff @(posedge clk) begin
    if (xfer) begin
      iss_a_q <= req_a[gnt_idx*M_W +: M_W];
      iss_b_q <= req_b[gnt_idx*N_W +: N_W];
    end
  end

  optmult #(
    .M_W      (M_W),
    .N_W      (N_W),
    .UNSIGNED (UNSIGNED)
  ) u_mult (
    .clk (clk),
    .rst (~rst),
    .a   (iss_a_q),
    .b   (iss_b_q),
    .out (mult_out)
  );

  assign res_valid = tag_vld_q[LAT-1];
  assign res_id    = tag_id_q[LAT-1];
  assign res_out   = res_valid ? mult_out : '0;

  always_comb begin
    busy = iss_vld_q;
    for (int s = 0; s < LAT; s++) busy = busy | tag_vld_q[s];
  end

`ifdef MULT_SHARE_ARB_STATS_EN
  logic [31:0] issue_cnt_q, starve_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (xfer) issue_cnt_q <= issue_cnt_q + 32'd1;
      if ((|req_valid) && !en) starve_cnt_q <= starve_cnt_q + 32'd1;
    end
  end

  assign issue_cnt  = issue_cnt_q;
  assign starve_cnt = starve_cnt_q;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Randomized bench for mult_share_arb: a signed 4-requester instance checked against a
// queue-based reference model, plus an unsigned instance checked with directed products.

module tb_mult_share_arb;

  localparam int LAT_S = 2;
  localparam int LAT_U = 3;

  typedef struct {
    int          id;
    logic [15:0] p;
    int          due;
  } item_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [15:0] res_out;
  logic        busy;

  logic        u_en;
  logic [3:0]  u_valid;
  logic [3:0]  u_ready;
  logic [31:0] u_a, u_b;
  logic        u_res_valid;
  logic [1:0]  u_res_id;
  logic [15:0] u_res_out;
  logic        u_busy;

`ifdef MULT_SHARE_ARB_STATS_EN
  logic [31:0] issue_cnt, starve_cnt, u_issue_cnt, u_starve_cnt;
`endif

  mult_share_arb #(.NUM_REQ(4), .M_W(8), .N_W(8), .UNSIGNED(0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_out   (res_out),
    .busy      (busy)
`ifdef MULT_SHARE_ARB_STATS_EN
    ,
    .issue_cnt (issue_cnt),
    .starve_cnt(starve_cnt)
`endif
  );

  mult_share_arb #(.NUM_REQ(4), .M_W(8), .N_W(8), .UNSIGNED(1)) u_dut_u (
    .clk       (clk),
    .rst       (rst),
    .en        (u_en),
    .req_valid (u_valid),
    .req_ready (u_ready),
    .req_a     (u_a),
    .req_b     (u_b),
    .res_valid (u_res_valid),
    .res_id    (u_res_id),
    .res_out   (u_res_out),
    .busy      (u_busy)
`ifdef MULT_SHARE_ARB_STATS_EN
    ,
    .issue_cnt (u_issue_cnt),
    .starve_cnt(u_starve_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          cyc;
  int          ptr;
  item_t       q[$];
  logic [31:0] iss_m, stv_m, u_iss_m;
  int          u_due;
  int          u_exp_id;
  logic [15:0] u_exp_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int exp_grant();
    int idx;
    if (!rst || !en) return -1;
    for (int k = 0; k < 4; k++) begin
      idx = (ptr + k) % 4;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] sprod(input logic [7:0] a, input logic [7:0] b);
    int r;
    r = int'($signed(a)) * int'($signed(b));
    return r[15:0];
  endfunction

  // One clock period: check outputs on the falling edge, advance the model on the rising edge.
  task automatic step();
    int          g;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic        u_exp_vld;
    item_t       it;
    g       = exp_grant();
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    @(negedge clk);
    exp_vld = (q.size() > 0) && (q[0].due == cyc);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(exp_vld));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("res_out", 32'(res_out), exp_vld ? 32'(q[0].p) : 32'd0);
    if (exp_vld) chk("res_id", 32'(res_id), 32'(q[0].id));
    if (!rst) chk("res_id_rst", 32'(res_id), 32'd0);
    u_exp_vld = (u_due >= 0) && (cyc == u_due);
    chk("u_ready", 32'(u_ready), rst ? 32'(u_valid) : 32'd0);
    chk("u_res_valid", 32'(u_res_valid), 32'(u_exp_vld));
    chk("u_busy", 32'(u_busy), 32'((u_due >= 0) && (cyc >= u_due - LAT_U) && (cyc <= u_due)));
    if (u_exp_vld) begin
      chk("u_res_id", 32'(u_res_id), 32'(u_exp_id));
      chk("u_res_out", 32'(u_res_out), 32'(u_exp_p));
    end
`ifdef MULT_SHARE_ARB_STATS_EN
    chk("issue_cnt", issue_cnt, iss_m);
    chk("starve_cnt", starve_cnt, stv_m);
    chk("u_issue_cnt", u_issue_cnt, u_iss_m);
    chk("u_starve_cnt", u_starve_cnt, 32'd0);
`endif
    @(posedge clk);
    if (rst) begin
      if (exp_vld) void'(q.pop_front());
      if (g >= 0) begin
        it.id  = g;
        it.p   = sprod(req_a[g*8 +: 8], req_b[g*8 +: 8]);
        it.due = cyc + 1 + LAT_S;
        q.push_back(it);
        ptr   = (g + 1) % 4;
        iss_m = iss_m + 32'd1;
      end
      if ((|req_valid) && !en) stv_m = stv_m + 32'd1;
      if (|u_valid) u_iss_m = u_iss_m + 32'd1;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    q.delete();
    ptr     = 0;
    iss_m   = '0;
    stv_m   = '0;
    u_iss_m = '0;
    u_due   = -1;
    step();
    rst = 1'b1;
  endtask

  task automatic u_issue(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] p);
    u_valid          = 4'(1 << id);
    u_a              = '0;
    u_b              = '0;
    u_a[id*8 +: 8]   = a;
    u_b[id*8 +: 8]   = b;
    u_due            = cyc + 1 + LAT_U;
    u_exp_id         = id;
    u_exp_p          = p;
    step();
    u_valid = '0;
    repeat (5) step();
    u_due = -1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    cyc       = 0;
    ptr       = 0;
    iss_m     = '0;
    stv_m     = '0;
    u_iss_m   = '0;
    u_due     = -1;
    u_exp_id  = 0;
    u_exp_p   = '0;
    rst       = 1'b0;
    en        = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    u_en      = 1'b1;
    u_valid   = '0;
    u_a       = '0;
    u_b       = '0;

    step();
    step();
    rst = 1'b1;
    step();

    // Single signed product: -3 * 7
    en           = 1'b1;
    req_a[7:0]   = 8'hFD;
    req_b[7:0]   = 8'd7;
    req_valid    = 4'b0001;
    step();
    req_valid = '0;
    repeat (4) step();

    // All four requesters streaming back to back
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i + 1);
      req_b[i*8 +: 8] = 8'd10;
    end
    req_valid = 4'hF;
    repeat (8) step();
    req_valid = '0;
    repeat (3) step();

    // Move the pointer to 2, then contend between requesters 1 and 3
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1010;
    repeat (8) step();
    req_valid = '0;
    repeat (4) step();

    // Two operations in flight, then en low for five cycles
    req_valid = 4'hF;
    step();
    step();
    en = 1'b0;
    repeat (5) step();
    req_valid = '0;
    repeat (2) step();
    en = 1'b1;

    // Reset mid-stream with three in flight
    req_valid = 4'hF;
    repeat (3) step();
    do_reset();
    repeat (3) step();
    req_valid = '0;
    repeat (4) step();

    // Unsigned instance
    u_issue(2, 8'd255, 8'd255, 16'd65025);
    u_issue(1, 8'd200, 8'd3, 16'd600);
    u_issue(0, 8'd128, 8'd255, 16'd32640);

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 600; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      en        = ($urandom_range(0, 7) != 0);
      req_a     = $urandom;
      req_b     = $urandom;
      if ($urandom_range(0, 49) == 0) do_reset();
      else step();
    end
    req_valid = '0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
